ex_mem_stage: RTL and testbench

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

---
 rtl/ex_mem_stage.sv | 185 ++++++++++++++++++
 tb/tb_ex_mem_stage.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX/MEM pipeline register built as a two-entry (head + skid)
// buffer with valid/ready handshakes, synchronous flush and an EX-to-EX
// forwarding tap taken from the head entry.
//
// Optional feature macro: EX_MEM_ZEROSIG_EN
//   defined   -> a zero flag is computed at push, stored per entry and shown
//                on out_zerosig for the head entry
//   undefined -> no flag storage or comparator, out_zerosig tied to 0
//
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid / in_ready             upstream handshake (in_ready registered)
//   alu_result, write_data          RESULT_W data from EX
//   write_reg, sig_*                destination register and control bits
//   flush                           synchronous discard of all entries
//   out_valid / out_ready           downstream handshake
//   out_*                           head entry contents (registered)
//   out_zerosig                     head entry's ALU result equals zero
//   fwd_valid, fwd_reg, fwd_data    bypass source derived from the head
module ex_mem_stage #(
  parameter int unsigned RESULT_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [RESULT_W-1:0] alu_result,
  input  logic [RESULT_W-1:0] write_data,
  input  logic [4:0]          write_reg,
  input  logic                sig_reg_write,
  input  logic                sig_mem_write,
  input  logic                sig_mem_to_reg,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RESULT_W-1:0] out_alu_result,
  output logic [RESULT_W-1:0] out_write_data,
  output logic [4:0]          out_write_reg,
  output logic                out_sig_reg_write,
  output logic                out_sig_mem_write,
  output logic                out_sig_mem_to_reg,
  output logic                out_zerosig,
  output logic                fwd_valid,
  output logic [4:0]          fwd_reg,
  output logic [RESULT_W-1:0] fwd_data
);

  localparam int unsigned REG_W = 5;

  typedef struct packed {
    logic [RESULT_W-1:0] alu_result;
    logic [RESULT_W-1:0] write_data;
    logic [REG_W-1:0]    write_reg;
    logic                reg_write;
    logic                mem_write;
    logic                mem_to_reg;
`ifdef EX_MEM_ZEROSIG_EN
    logic                zero;
`endif
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;
  logic   out_valid_q, out_valid_d;
  logic   fwd_valid_q, fwd_valid_d;

  entry_t in_entry;
  logic   push;
  logic   pop;

  // Pack the incoming instruction into an entry.
  always_comb begin
    in_entry            = '0;
    in_entry.alu_result = alu_result;
    in_entry.write_data = write_data;
    in_entry.write_reg  = write_reg;
    in_entry.reg_write  = sig_reg_write;
    in_entry.mem_write  = sig_mem_write;
    in_entry.mem_to_reg = sig_mem_to_reg;
`ifdef EX_MEM_ZEROSIG_EN
    in_entry.zero       = (alu_result == '0);
`endif
  end

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid_q && out_ready;

  // Next-state and entry movement. A vacated head is zeroed so that the
  // registered outputs read 0 whenever out_valid is low.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (push) begin
            head_d  = in_entry;
            state_d = HALF;
          end
        end
        HALF: begin
          if (push && pop) begin
            head_d = in_entry;
          end else if (push) begin
            skid_d  = in_entry;
            state_d = FULL;
          end else if (pop) begin
            head_d  = '0;
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            head_d  = skid_q;
            skid_d  = '0;
            state_d = HALF;
          end
        end
        default: begin
          state_d = EMPTY;
          head_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // Handshake and forwarding flags precomputed from the next state.
  always_comb begin
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
    fwd_valid_d = out_valid_d && head_d.reg_write && !head_d.mem_to_reg &&
                  (head_d.write_reg != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      fwd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      fwd_valid_q <= fwd_valid_d;
    end
  end

  assign in_ready           = in_ready_q;
  assign out_valid          = out_valid_q;
  assign out_alu_result     = head_q.alu_result;
  assign out_write_data     = head_q.write_data;
  assign out_write_reg      = head_q.write_reg;
  assign out_sig_reg_write  = head_q.reg_write;
  assign out_sig_mem_write  = head_q.mem_write;
  assign out_sig_mem_to_reg = head_q.mem_to_reg;
  assign fwd_valid          = fwd_valid_q;
  assign fwd_reg            = head_q.write_reg;
  assign fwd_data           = head_q.alu_result;

`ifdef EX_MEM_ZEROSIG_EN
  assign out_zerosig = head_q.zero;
`else
  assign out_zerosig = 1'b0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: directed scenarios plus randomized traffic, checked
// by a scoreboard. The reference model is an in-order queue of at most two
// accepted instructions; a monitor compares the DUT head against the queue
// front every cycle.
module tb_ex_mem_stage;

  localparam int unsigned W = 32;

  typedef struct {
    logic [W-1:0] alu;
    logic [W-1:0] wd;
    logic [4:0]   wr;
    logic         rw;
    logic         mw;
    logic         m2r;
  } item_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] alu_result = '0;
  logic [W-1:0] write_data = '0;
  logic [4:0]   write_reg = '0;
  logic         sig_reg_write = 1'b0;
  logic         sig_mem_write = 1'b0;
  logic         sig_mem_to_reg = 1'b0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_alu_result;
  logic [W-1:0] out_write_data;
  logic [4:0]   out_write_reg;
  logic         out_sig_reg_write;
  logic         out_sig_mem_write;
  logic         out_sig_mem_to_reg;
  logic         out_zerosig;
  logic         fwd_valid;
  logic [4:0]   fwd_reg;
  logic [W-1:0] fwd_data;

  ex_mem_stage #(.RESULT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .write_data(write_data), .write_reg(write_reg),
    .sig_reg_write(sig_reg_write), .sig_mem_write(sig_mem_write),
    .sig_mem_to_reg(sig_mem_to_reg), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_alu_result(out_alu_result),
    .out_write_data(out_write_data), .out_write_reg(out_write_reg),
    .out_sig_reg_write(out_sig_reg_write), .out_sig_mem_write(out_sig_mem_write),
    .out_sig_mem_to_reg(out_sig_mem_to_reg), .out_zerosig(out_zerosig),
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  item_t exp_q[$];
  item_t pend_item;
  logic  pend_push = 1'b0;
  logic  pend_flush = 1'b0;

`ifdef EX_MEM_ZEROSIG_EN
  localparam bit ZS_EN = 1'b1;
`else
  localparam bit ZS_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus: commit the previous cycle's accepted push (or
  // flush) into the model, then drive new inputs just after the edge.
  task automatic tick(input logic v, input logic [W-1:0] a, input logic [W-1:0] wd,
                      input logic [4:0] wr, input logic rw, input logic mw,
                      input logic m2r, input logic ordy, input logic fl);
    @(posedge clk);
    if (pend_flush) exp_q.delete();
    else if (pend_push) exp_q.push_back(pend_item);
    #1;
    in_valid       = v;
    alu_result     = a;
    write_data     = wd;
    write_reg      = wr;
    sig_reg_write  = rw;
    sig_mem_write  = mw;
    sig_mem_to_reg = m2r;
    out_ready      = ordy;
    flush          = fl;
    pend_item      = '{alu: a, wd: wd, wr: wr, rw: rw, mw: mw, m2r: m2r};
    pend_push      = v && (exp_q.size() < 2);
    pend_flush     = fl;
  endtask

  task automatic idle(input logic ordy);
    tick(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  task automatic push_simple(input logic [W-1:0] a, input logic ordy);
    tick(1'b1, a, ~a, 5'd7, 1'b1, 1'b0, 1'b0, ordy, 1'b0);
  endtask

  // Monitor: compare the DUT against the model queue, retire accepted heads.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
      chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        item_t e;
        e = exp_q[0];
        chk("head_alu", 64'(out_alu_result), 64'(e.alu));
        chk("head_wdata", 64'(out_write_data), 64'(e.wd));
        chk("head_ctrl", 64'({out_write_reg, out_sig_reg_write, out_sig_mem_write, out_sig_mem_to_reg}),
            64'({e.wr, e.rw, e.mw, e.m2r}));
        chk("zerosig", 64'(out_zerosig), 64'(ZS_EN && (e.alu == 0)));
        chk("fwd", 64'({fwd_valid, fwd_reg, fwd_data}),
            64'({e.rw && !e.m2r && (e.wr != 0), e.wr, e.alu}));
        if (out_ready && !pend_flush) void'(exp_q.pop_front());
      end else begin
        chk("idle_quiet", 64'({out_sig_reg_write, out_sig_mem_write, fwd_valid, out_zerosig}), 64'(0));
      end
    end
  end

  initial begin
    // Reset state while held in reset
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_alu", 64'(out_alu_result), 64'(0));
    #10 rst_n = 1'b1;

    // Single push with forwarding
    tick(1'b1, 32'h5, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    @(negedge clk);
    chk("single_valid", 64'(out_valid), 64'(1));
    chk("single_alu", 64'(out_alu_result), 64'h5);
    chk("single_fwd_valid", 64'(fwd_valid), 64'(1));
    chk("single_fwd_reg", 64'(fwd_reg), 64'(3));
    idle(1'b1);

    // Forward gating: r0 destination, then load result
    tick(1'b1, 32'h9, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    @(negedge clk);
    chk("fwd_r0", 64'(fwd_valid), 64'(0));
    tick(1'b1, 32'h9, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    @(negedge clk);
    chk("fwd_load", 64'(fwd_valid), 64'(0));
    idle(1'b1);

    // Backpressure: fill, then drain on consecutive cycles
    push_simple(32'hA, 1'b0);
    push_simple(32'hB, 1'b0);
    idle(1'b0);
    @(negedge clk);
    chk("bp_full_ready", 64'(in_ready), 64'(0));
    chk("bp_head_hold", 64'(out_alu_result), 64'hA);
    idle(1'b1);
    @(negedge clk);
    chk("bp_first", 64'(out_alu_result), 64'hA);
    idle(1'b1);
    @(negedge clk);
    chk("bp_second", 64'(out_alu_result), 64'hB);
    idle(1'b1);
    @(negedge clk);
    chk("bp_drained", 64'(out_valid), 64'(0));

    // Flush in FULL with a pending push, then flush in HALF with a push
    push_simple(32'h1, 1'b0);
    push_simple(32'h2, 1'b0);
    idle(1'b0);
    tick(1'b1, 32'hC, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    @(negedge clk);
    chk("flush_full_valid", 64'(out_valid), 64'(0));
    chk("flush_full_ready", 64'(in_ready), 64'(1));
    push_simple(32'h1, 1'b0);
    tick(1'b1, 32'hC, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    @(negedge clk);
    chk("flush_half_valid", 64'(out_valid), 64'(0));

    // Zero flag
    push_simple(32'h0, 1'b0);
    idle(1'b0);
    @(negedge clk);
    chk("zero_flag_set", 64'(out_zerosig), 64'(ZS_EN));
    idle(1'b1);
    push_simple(32'h1, 1'b0);
    idle(1'b1);
    @(negedge clk);
    chk("zero_flag_clr", 64'(out_zerosig), 64'(0));
    idle(1'b1);

    // Asynchronous reset while FULL
    push_simple(32'h11, 1'b0);
    push_simple(32'h22, 1'b0);
    idle(1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'(0));
    chk("arst_ready", 64'(in_ready), 64'(1));
    chk("arst_alu", 64'(out_alu_result), 64'(0));
    chk("arst_fwd", 64'(fwd_valid), 64'(0));
    exp_q.delete();
    pend_push  = 1'b0;
    pend_flush = 1'b0;
    in_valid   = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    push_simple(32'h33, 1'b1);
    idle(1'b1);
    @(negedge clk);
    chk("post_rst_push", 64'(out_alu_result), 64'h33);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [W-1:0] a;
      a = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      tick(1'($urandom_range(0, 3) != 0), a, W'($urandom), 5'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 31) == 0));
    end
    repeat (4) idle(1'b1);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
